// File: rtl/spi_stream.sv
// 3-wire SPI master: multi-word transactions with CSB held low across words,
// per-word write/read direction, CPOL=0, MSB first, shared bidirectional SDIO.
module spi_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    inout  wire               SDIO,
    output logic              SCLK,
    output logic              CSB,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_read_i,
    input  logic              tx_last_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned TglW = $clog2(2 * DATA_W);
    localparam logic [TglW-1:0] LastTgl = TglW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StLoad, StShift, StHold} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [TglW-1:0]     tgl_q, tgl_d;
    logic                sclk_q, sclk_d;
    logic                csb_q, csb_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic                rd_q, rd_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                done_q, done_d;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        tgl_d      = tgl_q;
        sclk_d     = sclk_q;
        csb_d      = csb_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rd_d       = rd_q;
        last_d     = last_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    div_d   = div_i;
                    cnt_d   = div_i;
                    csb_d   = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) state_d = StLoad;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StLoad: begin
                if (tx_valid_i) begin
                    tx_sr_d = tx_data_i;
                    rd_d    = tx_read_i;
                    last_d  = tx_last_i;
                    cnt_d   = div_q;
                    tgl_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == '0) begin
                    // Counting down from div avoids overflow when div is all-ones.
                    cnt_d  = div_q;
                    sclk_d = ~sclk_q;
                    tgl_d  = tgl_q + 1'b1;
                    if (!sclk_q) begin
                        if (rd_q) rx_sr_d = {rx_sr_q[DATA_W-2:0], SDIO};
                    end else begin
                        tx_sr_d = tx_sr_q << 1;
                    end
                    if (tgl_q == LastTgl) begin
                        if (rd_q) begin
                            rx_data_d  = rx_sr_q;
                            rx_valid_d = 1'b1;
                        end
                        state_d = last_q ? StHold : StLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    csb_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            div_q      <= '0;
            cnt_q      <= '0;
            tgl_q      <= '0;
            sclk_q     <= 1'b0;
            csb_q      <= 1'b1;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rd_q       <= 1'b0;
            last_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            tgl_q      <= tgl_d;
            sclk_q     <= sclk_d;
            csb_q      <= csb_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rd_q       <= rd_d;
            last_q     <= last_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
        end
    end

    // Only a write word in flight owns the pin; everything else leaves it floating.
    assign SDIO       = (state_q == StShift && !rd_q) ? tx_sr_q[DATA_W-1] : 1'bz;
    assign SCLK       = sclk_q;
    assign CSB        = csb_q;
    assign tx_ready_o = (state_q == StLoad);
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q != StIdle) || start_i;
    assign done_o     = done_q;

endmodule

// File: doc/spi_stream.md
# spi_stream

Parametrised 3-wire SPI master that runs multi-word transactions with CSB held low across words. Word width, SCLK rate and per-word direction are configurable. It sits between register-programming sequencers and the shared bidirectional SDIO pin of an external converter/PLL. A transaction is opened with `start_i`; words are fed through a valid/ready stream, and each word is marked write or read.

## Interface
Parameters:
- `DATA_W`, default 8: bits per word; MSB first; legal values 2..32.
- `DIV_W`, default 8: width of the SCLK half-period divider.

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `SDIO`  inout  1  bidirectional serial data; driven only while shifting a write word, otherwise `Z`.
- `SCLK`  out  1  serial clock; idles low (CPOL=0).
- `CSB`  out  1  chip select, active-low.
- `div_i`  in  DIV_W  SCLK half-period is `div_i+1` CLK cycles; latched on an accepted `start_i`.
- `start_i`  in  1  open a transaction; accepted only in IDLE.
- `tx_data_i`  in  DATA_W  word to shift out (don't-care for read words).
- `tx_read_i`  in  1  1 = read word (SDIO released and sampled); 0 = write word.
- `tx_last_i`  in  1  1 = final word of the transaction.
- `tx_valid_i`  in  1  word-stream valid.
- `tx_ready_o`  out  1  word-stream ready; a word is accepted when `tx_valid_i && tx_ready_o`.
- `rx_data_o`  out  DATA_W  last completed read word.
- `rx_valid_o`  out  1  one-cycle pulse when `rx_data_o` updates.
- `busy_o`  out  1  high when not in IDLE, or when `start_i` is high in IDLE.
- `done_o`  out  1  one-cycle pulse on the first IDLE cycle after a transaction.

## Operation
- Reset values:
  - `SCLK`=0, `CSB`=1, `SDIO`=Z.
  - `tx_ready_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `done_o`=0.
  - Internal `busy_o` term 0; state IDLE.
- States:
  - **IDLE**
    - `CSB`=1.
    - On `start_i`: latch `div_i`, `CSB`<=0, go to SETUP.
  - **SETUP**
    - Wait `div+1` cycles (CSB-to-first-edge setup), then go to LOAD.
  - **LOAD**
    - `tx_ready_o`=1 (combinational from state).
    - On `tx_valid_i`: latch data, read and last flags, then go to SHIFT.
    - Stays in LOAD indefinitely if `tx_valid_i` is low; `CSB` stays low and `SCLK` stays low.
  - **SHIFT**
    - Half-period counter loaded with `div` on entry. It decrements each cycle; at 0 it toggles `SCLK` and reloads.
    - Rising toggle (0→1): for a read word, sample `SDIO` into the rx shift register LSB.
    - Falling toggle (1→0): shift the tx register left, so `SDIO` presents the next bit.
    - After `2*DATA_W` toggles (the last one is falling), the word completes:
      - For a read word: `rx_data_o` <= shift register, `rx_valid_o` pulses.
      - If last: go to HOLD. Otherwise: go to LOAD.
  - **HOLD**
    - Wait `div+1` cycles with `SCLK`=0, then `CSB`<=1, go to IDLE, pulse `done_o`.
- SDIO drive:
  - `SDIO` is enabled only in SHIFT of a write word; it carries the tx MSB.
  - It is released in SETUP, LOAD, HOLD and IDLE, and throughout read words.
- Boundary conditions:
  - `start_i` while not IDLE is ignored; no queuing.
  - `tx_valid_i` outside LOAD is ignored.
  - A write word has `rx_valid_o` low and leaves `rx_data_o` unchanged.
  - `div_i` changes mid-transaction have no effect.
  - `div_i`=0 gives `SCLK` = CLK/2.
  - `div_i`=all-ones gives a half-period of `2^DIV_W` cycles; the counter must not overflow.
  - Reset asserted mid-transaction returns all outputs to reset values immediately (asynchronously). No `done_o` or `rx_valid_o` is produced for the aborted transaction.

## Timing
- `start_i` accepted at cycle 0 → `CSB` low from cycle 1.
- CSB-low duration for N words with `tx_valid_i` always high: `(div+1) + N*(1 + 2*DATA_W*(div+1)) + (div+1)` cycles.
- SCLK period is `2*(div+1)` cycles. First rising edge is `div+1` cycles after SHIFT entry.
- Inter-word gap is at least 1 LOAD cycle, with `SCLK` low, between the last falling edge and the next word's first data.
- `rx_valid_o` is asserted in the cycle after the final falling toggle of a read word; `rx_data_o` is stable from that cycle.
- `done_o` coincides with the first `CSB`=1 cycle. A new `start_i` is accepted in that same cycle, so the minimum CSB-high time is 1 cycle.

## Test plan
- DATA_W=8, div=0, single write word 0xA5 with last=1:
  - `SDIO` = 1,0,1,0,0,1,0,1, stable across each rising `SCLK`.
  - 8 `SCLK` pulses; `CSB` low 19 cycles.
  - `done_o` pulses once; `rx_valid_o` never fires.
- Two-word transaction: write 0x80, then read with last=1; bench drives 0x3C on rising edges during the read word:
  - `SDIO` is Z by the DUT throughout the read word.
  - `rx_data_o`=0x3C with one `rx_valid_o` pulse.
  - `CSB` stays low continuously across both words.
- div=3, one write word 0xFF:
  - SCLK period 8 CLK; `CSB` low 4+1+64+4 = 73 cycles.
- Stall: second word withheld for 10 cycles:
  - `tx_ready_o` stays high; `SCLK` holds 0 and `CSB` holds 0 during the stall.
  - Transfer resumes 1 cycle after `tx_valid_i`.
- Reset mid-word (after 5 SCLK pulses):
  - `CSB`=1, `SCLK`=0, `SDIO`=Z immediately.
  - No `done_o`; the next transaction after reset completes normally.
  - `start_i` pulsed while busy is ignored.
- DATA_W=16, div=1, read word; bench drives 0xBEEF:
  - `rx_data_o`=0xBEEF; 16 SCLK pulses per word.
